// File: rtl/crc24_pkg.sv
// rtl/crc24_pkg.sv - CRC-24 constants, byte-index type and per-byte CRC function
package crc24_pkg;

  localparam int CRC_W = 24;
  localparam logic [CRC_W-1:0] CRC_POLY = 24'h864CFB;

  // Position of the next expected byte inside a 4-byte codeword
  typedef enum logic [1:0] {
    IDX_DATA    = 2'd0,
    IDX_CRC_HI  = 2'd1,
    IDX_CRC_MID = 2'd2,
    IDX_CRC_LO  = 2'd3
  } byte_idx_e;

  // MSB-first LFSR over one data byte, zero init; shared with the encoder side
  function automatic logic [CRC_W-1:0] crc24_byte(input logic [7:0] data);
    logic [CRC_W-1:0] crc;
    crc = {data, {(CRC_W-8){1'b0}}};
    for (int i = 0; i < 8; i++) begin
      if (crc[CRC_W-1]) begin
        crc = {crc[CRC_W-2:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc = {crc[CRC_W-2:0], 1'b0};
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/crc24_byte_calc.sv
// rtl/crc24_byte_calc.sv - combinational CRC-24 of a single data byte
module crc24_byte_calc
  import crc24_pkg::*;
(
  input  logic [7:0]       data_i,
  output logic [CRC_W-1:0] crc_o
);

  assign crc_o = crc24_byte(data_i);

endmodule

// File: rtl/crc24_axis_checker.sv
// rtl/crc24_axis_checker.sv - stream checker for {data, crc24} codewords with error counters
module crc24_axis_checker
  import crc24_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter bit          DROP_ON_ERROR = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tuser,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  output logic [CNT_W-1:0] ok_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  byte_idx_e        idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [CRC_W-1:0] exp_q, exp_d;
  logic [7:0]       crc_hi_q, crc_hi_d;
  logic [7:0]       crc_mid_q, crc_mid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_user_q, out_user_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] crc_err_q, crc_err_d;
  logic [CNT_W-1:0] frm_err_q, frm_err_d;
  logic [CNT_W-1:0] ok_q, ok_d;

  logic [CRC_W-1:0] calc_crc;
  logic             accept;
  logic             crc_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  crc24_byte_calc u_calc (
    .data_i (s_tdata),
    .crc_o  (calc_crc)
  );

  // Only the final byte can stall, and only while an undrained result blocks the output slot
  assign s_tready  = !(idx_q == IDX_CRC_LO && out_valid_q && !m_tready);
  assign accept    = s_tvalid && s_tready;
  assign crc_match = ({crc_hi_q, crc_mid_q, s_tdata} == exp_q);

  assign m_tdata     = out_data_q;
  assign m_tuser     = out_user_q;
  assign m_tvalid    = out_valid_q;
  assign crc_err_cnt = crc_err_q;
  assign frm_err_cnt = frm_err_q;
  assign ok_cnt      = ok_q;

  // Byte-index sequencing, capture, compare, output slot and counter updates
  always_comb begin
    idx_d       = idx_q;
    data_d      = data_q;
    exp_d       = exp_q;
    crc_hi_d    = crc_hi_q;
    crc_mid_d   = crc_mid_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_valid_d = out_valid_q;
    crc_err_d   = crc_err_q;
    frm_err_d   = frm_err_q;
    ok_d        = ok_q;

    if (out_valid_q && m_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (idx_q)
        IDX_DATA: begin
          data_d = s_tdata;
          exp_d  = calc_crc;
          idx_d  = IDX_CRC_HI;
        end
        IDX_CRC_HI: begin
          crc_hi_d = s_tdata;
          idx_d    = IDX_CRC_MID;
        end
        IDX_CRC_MID: begin
          crc_mid_d = s_tdata;
          idx_d     = IDX_CRC_LO;
        end
        IDX_CRC_LO: begin
          idx_d = IDX_DATA;
          if (crc_match) begin
            ok_d        = sat_inc(ok_q);
            out_data_d  = data_q;
            out_user_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            crc_err_d = sat_inc(crc_err_q);
            if (!DROP_ON_ERROR) begin
              out_data_d  = data_q;
              out_user_d  = 1'b1;
              out_valid_d = 1'b1;
            end
          end
        end
        default: idx_d = IDX_DATA;
      endcase

      // An early delimiter truncates the codeword; tlast on the last byte is just framing
      if (s_tlast && idx_q != IDX_CRC_LO) begin
        idx_d     = IDX_DATA;
        frm_err_d = sat_inc(frm_err_q);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q       <= IDX_DATA;
      data_q      <= '0;
      exp_q       <= '0;
      crc_hi_q    <= '0;
      crc_mid_q   <= '0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_valid_q <= 1'b0;
      crc_err_q   <= '0;
      frm_err_q   <= '0;
      ok_q        <= '0;
    end else begin
      idx_q       <= idx_d;
      data_q      <= data_d;
      exp_q       <= exp_d;
      crc_hi_q    <= crc_hi_d;
      crc_mid_q   <= crc_mid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_valid_q <= out_valid_d;
      crc_err_q   <= crc_err_d;
      frm_err_q   <= frm_err_d;
      ok_q        <= ok_d;
    end
  end

endmodule

// File: tb/tb_crc24_axis_checker.sv
// tb/tb_crc24_axis_checker.sv - self-checking bench for crc24_axis_checker
module tb_crc24_axis_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b1;

  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tuser;
  logic [15:0] crc_err_cnt, frm_err_cnt, ok_cnt;

  logic        d_s_tvalid;
  logic        d_s_tready;
  logic [7:0]  d_m_tdata;
  logic        d_m_tvalid;
  logic        d_m_tuser;
  logic        d_m_tready;
  logic [1:0]  d_crc_err_cnt, d_frm_err_cnt, d_ok_cnt;

  always #5 clk = ~clk;

  // Drop-mode instance sees exactly the bytes the main instance accepts
  assign d_s_tvalid = s_tvalid & s_tready;
  assign d_m_tready = 1'b1;

  crc24_axis_checker #(.CNT_W(16), .DROP_ON_ERROR(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .crc_err_cnt(crc_err_cnt), .frm_err_cnt(frm_err_cnt), .ok_cnt(ok_cnt)
  );

  crc24_axis_checker #(.CNT_W(2), .DROP_ON_ERROR(1'b1)) dut_drop (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(d_s_tvalid), .s_tready(d_s_tready), .s_tlast(s_tlast),
    .m_tdata(d_m_tdata), .m_tvalid(d_m_tvalid), .m_tready(d_m_tready), .m_tuser(d_m_tuser),
    .crc_err_cnt(d_crc_err_cnt), .frm_err_cnt(d_frm_err_cnt), .ok_cnt(d_ok_cnt)
  );

  int tests = 0;
  int errors = 0;

  int m_ok = 0, m_crc = 0, m_frm = 0;
  logic [7:0] cw_q[$];
  logic [8:0] exp_main[$];
  logic [8:0] exp_drop[$];
  int main_outs = 0, drop_outs = 0;
  bit stall_seen = 0;
  bit rnd_on = 0;

  typedef struct {
    logic [31:0] cw;
    logic        user;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of d(x)*x^24 divided by the full 25-bit generator
  function automatic logic [23:0] ref_crc(input logic [7:0] d);
    logic [31:0] r;
    r = {d, 24'h000000};
    for (int i = 31; i >= 24; i--) begin
      if (r[i]) r = r ^ (32'h01864CFB << (i - 24));
    end
    return r[23:0];
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_byte(input logic [7:0] b, input logic last);
    logic [23:0] rx;
    cw_q.push_back(b);
    if (cw_q.size() == 4) begin
      rx = {cw_q[1], cw_q[2], cw_q[3]};
      if (rx == ref_crc(cw_q[0])) begin
        m_ok++;
        exp_main.push_back({cw_q[0], 1'b0});
        exp_drop.push_back({cw_q[0], 1'b0});
      end else begin
        m_crc++;
        exp_main.push_back({cw_q[0], 1'b1});
      end
      cw_q.delete();
    end else if (last) begin
      m_frm++;
      cw_q.delete();
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_ok"},      ok_cnt,        sat(m_ok, 65535));
    chk({tag, "_crcerr"},  crc_err_cnt,   sat(m_crc, 65535));
    chk({tag, "_frmerr"},  frm_err_cnt,   sat(m_frm, 65535));
    chk({tag, "_d_ok"},    d_ok_cnt,      sat(m_ok, 3));
    chk({tag, "_d_crcerr"}, d_crc_err_cnt, sat(m_crc, 3));
    chk({tag, "_d_frmerr"}, d_frm_err_cnt, sat(m_frm, 3));
  endtask

  // Output scoreboard, hold-stability check and input-side model update
  initial begin
    logic [8:0] e;
    logic       prev_v, prev_r, prev_u;
    logic [7:0] prev_d;
    prev_v = 0; prev_r = 0; prev_u = 0; prev_d = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_v && !prev_r) begin
          chk("hold_valid", m_tvalid, 1);
          chk("hold_data", m_tdata, prev_d);
          chk("hold_user", m_tuser, prev_u);
        end
        prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_u = m_tuser;
        if (m_tvalid && m_tready) begin
          main_outs++;
          chk("main_expected", exp_main.size() != 0, 1);
          if (exp_main.size() != 0) begin
            e = exp_main.pop_front();
            chk("main_data", m_tdata, e[8:1]);
            chk("main_user", m_tuser, e[0]);
          end
        end
        if (d_m_tvalid) begin
          drop_outs++;
          chk("drop_expected", exp_drop.size() != 0, 1);
          if (exp_drop.size() != 0) begin
            e = exp_drop.pop_front();
            chk("drop_data", d_m_tdata, e[8:1]);
            chk("drop_user", d_m_tuser, e[0]);
          end
        end
        if (s_tvalid && !s_tready) stall_seen = 1;
        if (s_tvalid && s_tready) model_byte(s_tdata, s_tlast);
      end else begin
        prev_v = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit hs;
    int n;
    hs = 0; n = 0;
    s_tdata = b; s_tlast = last; s_tvalid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      tests++; errors++;
      $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", b);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_cw(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8], j == 3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    s_tvalid = 1'b0;
    cw_q.delete(); exp_main.delete(); exp_drop.delete();
    m_ok = 0; m_crc = 0; m_frm = 0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base_m, base_d;
    bit found;
    logic [7:0]  data;
    logic [31:0] word;
    int k;

    tbl[0] = '{32'h01864CFB, 1'b0};
    tbl[1] = '{32'h00000000, 1'b0};
    tbl[2] = '{32'h028AD50D, 1'b0};
    tbl[3] = '{32'h01864CFA, 1'b1};
    tbl[4] = '{32'h00000001, 1'b1};
    tbl[5] = '{32'h028AD50C, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_d_s_tready", d_s_tready, 1);
    check_counters("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Directed codeword table
    for (int i = 0; i < 6; i++) begin
      base_d = drop_outs;
      send_cw(tbl[i].cw);
      found = 0;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge clk);
        if (m_tvalid) begin
          found = 1;
          chk("tbl_data", m_tdata, tbl[i].cw[31:24]);
          chk("tbl_user", m_tuser, tbl[i].user);
        end
      end
      chk("tbl_seen", found, 1);
      idle(3);
      chk("tbl_drop_outs", drop_outs - base_d, tbl[i].user ? 0 : 1);
    end
    chk("tbl_ok_cnt", ok_cnt, 3);
    chk("tbl_crc_err_cnt", crc_err_cnt, 3);
    chk("tbl_d_crc_err_cnt", d_crc_err_cnt, 3);

    // Back-to-back codewords at full rate
    stall_seen = 0;
    base_m = main_outs;
    send_cw(32'h00000000);
    send_cw(32'h028AD50D);
    idle(3);
    chk("b2b_outs", main_outs - base_m, 2);
    chk("b2b_no_stall", stall_seen, 0);
    chk("b2b_ok_cnt", ok_cnt, 5);

    // Truncated codeword followed by a good one
    base_m = main_outs;
    send_byte(8'h01, 1'b0);
    send_byte(8'h86, 1'b1);
    send_cw(32'h00000000);
    idle(3);
    chk("trunc_frm_cnt", frm_err_cnt, 1);
    chk("trunc_d_frm_cnt", d_frm_err_cnt, 1);
    chk("trunc_ok_cnt", ok_cnt, 6);
    chk("trunc_outs", main_outs - base_m, 1);

    // Backpressure: second codeword's last byte waits for the first result to drain
    m_tready = 1'b0;
    base_m = main_outs;
    fork
      begin
        send_cw(32'h01864CFB);
        send_cw(32'h028AD50D);
      end
      begin
        repeat (15) @(negedge clk);
        chk("bp_s_tready_low", s_tready, 0);
        chk("bp_m_tvalid", m_tvalid, 1);
        chk("bp_m_tdata", m_tdata, 8'h01);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    idle(4);
    chk("bp_outs", main_outs - base_m, 2);
    chk("bp_queue_empty", exp_main.size(), 0);
    check_counters("bp");

    // Reset in the middle of a codeword
    send_byte(8'h01, 1'b0);
    send_byte(8'h86, 1'b0);
    send_byte(8'h4C, 1'b0);
    do_reset(2);
    @(negedge clk);
    chk("mrst_m_tvalid", m_tvalid, 0);
    chk("mrst_s_tready", s_tready, 1);
    check_counters("mrst");
    idle(1);
    send_cw(32'h01864CFB);
    idle(3);
    chk("mrst_ok_cnt", ok_cnt, 1);
    chk("mrst_crc_err_cnt", crc_err_cnt, 0);
    chk("mrst_frm_err_cnt", frm_err_cnt, 0);

    // Randomized traffic with corruption, truncation, gaps and backpressure
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(3) != 0);
        end
      end
      begin
        for (int c = 0; c < 250; c++) begin
          data = 8'($urandom);
          word = {data, ref_crc(data)};
          if ($urandom_range(3) == 0) word[$urandom_range(23)] ^= 1'b1;
          if ($urandom_range(9) == 0) begin
            k = $urandom_range(3, 1);
            for (int j = 0; j < k; j++) send_byte(word[31-8*j -: 8], j == k - 1);
          end else begin
            for (int j = 0; j < 4; j++)
              send_byte(word[31-8*j -: 8], (j == 3) ? 1'($urandom_range(1)) : 1'b0);
          end
          if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
        end
        rnd_on = 0;
      end
    join
    m_tready = 1'b1;
    idle(8);
    chk("rnd_main_queue_empty", exp_main.size(), 0);
    chk("rnd_drop_queue_empty", exp_drop.size(), 0);
    check_counters("rnd");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
